imem_rr_arbiter: RTL and testbench
==================================

# imem_rr_arbiter

Round-robin arbiter that shares one single-port instruction memory between `nCPUs` single-cycle CPUs inside `cpu_cluster`. Each cycle it grants at most one CPU's fetch request and drives the shared memory address. One cycle later it returns the fetched word to that CPU with a one-hot valid. A CPU whose request is not granted stalls. Per-CPU wait counters expose arbitration fairness to the bench.

## Interface
Parameters:
- `nCPUs`, 3: number of requesting CPUs; legal range is 2..8.
- `WAIT_W`, 4: width of each saturating wait counter.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  `nCPUs`: per-CPU fetch request.
- `addr`  in  `[nCPUs-1:0][31:0]`: per-CPU fetch byte address (PC).
- `gnt`  out  `nCPUs`: one-hot grant. Combinational from `req` and the priority pointer.
- `stall`  out  `nCPUs`: `req & ~gnt`; the CPU holds its PC while high.
- `rvalid`  out  `nCPUs`: one-hot; the fetched word is for this CPU.
- `rdata`  out  32: fetched instruction. Shared bus, qualified by `rvalid`.
- `memEn`  out  1: memory read enable; equals `|req`.
- `memAddr`  out  32: `addr` of the granted CPU; 0 when idle.
- `memRdata`  in  32: memory read data. Valid the cycle after `memEn`.
- `waitCnt`  out  `[nCPUs-1:0][WAIT_W-1:0]`: consecutive stalled cycles per CPU.

## Operation
- The priority pointer `ptr` ranges 0..nCPUs-1. The winner is the first `i` with `req[i]` set, searching `ptr`, `ptr+1`, … and wrapping modulo `nCPUs`.
- `gnt`, `memEn`, `memAddr` and `stall` are combinational in the same cycle.
- After a cycle with a grant to CPU `k`, `ptr` becomes `(k+1) mod nCPUs`. The wrap from `nCPUs-1` goes to 0.
- With no requests, `ptr` holds.
- Response path:
  - The one-hot grant is registered into `rvalid`.
  - `rdata` passes `memRdata` through combinationally, so data and valid are aligned.
- Only one fetch is outstanding at a time; no queueing or buffering beyond the `rvalid` register.
- `addr` is not latched. A CPU that changes `addr` while stalled is served at its address in the grant cycle.
- Dropping `req` before a grant is legal and costs nothing.
- Wait counters:
  - `waitCnt[i]` increments when `stall[i]` is high and saturates at all-ones.
  - It clears to 0 in any cycle where `req[i]` is low or `gnt[i]` is high.
- Under continuous requests from all CPUs, no CPU waits more than `nCPUs-1` consecutive cycles.

## Timing
- Reset, asynchronous on `rst` low: `ptr=0`, `rvalid=0`, all `waitCnt=0`.
- During reset, `gnt`, `memEn`, `memAddr` and `stall` still follow `req` using `ptr=0`.
- Reset asserted with a response pending: `rvalid` drops immediately and the response is discarded.
- Grant latency is 0 cycles (same cycle as `req`). Data latency is 1 cycle after the grant.
- Back-to-back grants are allowed every cycle, to the same or a different CPU.
- Grant and data can overlap: in one cycle, `gnt[j]` for a new fetch and `rvalid[k]` for the previous fetch are both high.
- When only one CPU requests, it is granted every cycle regardless of `ptr`.

## Structure
- Package `cpu_cluster_pkg` holds:
  - the 32-bit instruction and address width constants;
  - the default `nCPUs`;
  - the `WAIT_W` constant, shared with `cpu_cluster` and the bench.
- Sub-module `rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req`, `ptr`. Outputs: one-hot `gnt` and the binary winner index.
  - Implemented as a double-width rotate followed by find-first.
- The top level contains the pointer register, the `rvalid` register, the wait counters and the address mux.

## Test plan
- Reset: `rst` low with `req=3'b111` → `gnt=3'b001`, `rvalid=0`, `waitCnt` all 0. Release `rst` → first grant is CPU0.
- Single requester: `req=3'b010`, `addr[1]=32'h30`, memory word `32'h00100513` → `gnt=3'b010` every cycle. Next cycle `rvalid=3'b010`, `rdata=32'h00100513`.
- Full contention: `req=3'b111` for 9 cycles → `gnt` sequence is 001, 010, 100, repeated 3 times. Each `waitCnt` peaks at 2. `rvalid` follows `gnt` delayed by 1 cycle.
- Wrap/skip: force `ptr=1` (grant CPU0 once), then `req=3'b101` → `gnt` goes 100, then 001, then 100.
- Idle: `req=0` for 1 cycle → `memEn=0`, `memAddr=0`, `ptr` unchanged, `rvalid=0` the following cycle.
- Mid-operation reset: assert `rst` low between a grant and its edge → `rvalid` stays 0 and `ptr` returns to 0.

Source files
------------

// File: rtl/cpu_cluster_pkg.sv
// Shared constants for the CPU cluster: instruction/address widths, the
// default number of CPUs sharing the instruction memory, and the width of
// the per-CPU arbitration wait counters.
package cpu_cluster_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 32;
  localparam int N_CPUS_DFLT = 3;
  localparam int WAIT_W_DFLT = 4;

endpackage

// File: rtl/imem_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
// Finds the first requester at or after the priority pointer, wrapping
// modulo nCPUs.
//   req : per-CPU request vector
//   ptr : current priority pointer (0..nCPUs-1)
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : binary index of the winner (don't-care when any is low)
//   any : at least one request is present
module rr_pick #(
  parameter int nCPUs = 3,
  parameter int PTR_W = $clog2(nCPUs)
) (
  input  logic [nCPUs-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [nCPUs-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  localparam logic [nCPUs-1:0] ONE_HOT0 = {{(nCPUs-1){1'b0}}, 1'b1};

  logic [nCPUs-1:0] rot;
  int               offset;
  int               winInt;

  always_comb begin
    // Shifting the doubled vector right by ptr puts req[ptr] at bit 0, so a
    // plain lowest-bit search yields the distance from ptr to the winner.
    rot    = nCPUs'({req, req} >> ptr);
    any    = |rot;
    offset = 0;
    for (int j = nCPUs - 1; j >= 0; j--) begin
      if (rot[j]) begin
        offset = j;
      end
    end
    winInt = int'(ptr) + offset;
    if (winInt >= nCPUs) begin
      winInt = winInt - nCPUs;
    end
    idx = PTR_W'(winInt);
    gnt = any ? (ONE_HOT0 << idx) : '0;
  end

endmodule

// File: rtl/imem_rr_arbiter.sv
// imem_rr_arbiter: round-robin arbiter sharing one single-port instruction
// memory between nCPUs single-cycle CPUs.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   req      : per-CPU fetch request
//   addr     : per-CPU fetch byte address
//   gnt      : one-hot grant, combinational, same cycle as req
//   stall    : req & ~gnt, CPU holds its PC while high
//   rvalid   : one-hot, fetched word on rdata belongs to this CPU
//   rdata    : fetched instruction (memRdata passed straight through)
//   memEn    : memory read enable (|req)
//   memAddr  : address of the granted CPU, 0 when idle
//   memRdata : memory read data, valid the cycle after memEn
//   waitCnt  : per-CPU saturating count of consecutive stalled cycles
module imem_rr_arbiter
  import cpu_cluster_pkg::*;
#(
  parameter int nCPUs  = N_CPUS_DFLT,
  parameter int WAIT_W = WAIT_W_DFLT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [nCPUs-1:0]               req,
  input  logic [nCPUs-1:0][ADDR_W-1:0]   addr,
  output logic [nCPUs-1:0]               gnt,
  output logic [nCPUs-1:0]               stall,
  output logic [nCPUs-1:0]               rvalid,
  output logic [INSTR_W-1:0]             rdata,
  output logic                           memEn,
  output logic [ADDR_W-1:0]              memAddr,
  input  logic [INSTR_W-1:0]             memRdata,
  output logic [nCPUs-1:0][WAIT_W-1:0]   waitCnt
);

  localparam int               PTR_W    = $clog2(nCPUs);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(nCPUs - 1);

  logic [PTR_W-1:0]             ptr;
  logic [PTR_W-1:0]             winIdx;
  logic                         anyGnt;
  logic [nCPUs-1:0]             vld_p1;
  logic [nCPUs-1:0][WAIT_W-1:0] waitQ;

  function automatic logic [WAIT_W-1:0] satInc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  rr_pick #(
    .nCPUs (nCPUs),
    .PTR_W (PTR_W)
  ) uPick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (winIdx),
    .any (anyGnt)
  );

  // Stage p0: request, grant and memory address in the same cycle
  always_comb begin
    memAddr = '0;
    for (int i = 0; i < nCPUs; i++) begin
      if (gnt[i]) begin
        memAddr = addr[i];
      end
    end
  end

  assign stall = req & ~gnt;
  assign memEn = |req;

  // Pointer moves just past the last winner; it holds when nobody requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (anyGnt) begin
      ptr <= (winIdx == PTR_LAST) ? '0 : winIdx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitQ <= '0;
    end else begin
      for (int i = 0; i < nCPUs; i++) begin
        if (!req[i] || gnt[i]) begin
          waitQ[i] <= '0;
        end else begin
          waitQ[i] <= satInc(waitQ[i]);
        end
      end
    end
  end

  assign waitCnt = waitQ;

  // Stage p1: memory returns data; grant delayed one cycle becomes rvalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= gnt;
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = memRdata;

endmodule

// File: tb/tb_imem_rr_arbiter.sv
`timescale 1ns/1ps
module tb_imem_rr_arbiter;
  import cpu_cluster_pkg::*;

  localparam int N  = 3;
  localparam int WW = WAIT_W_DFLT;

  typedef struct {
    logic [N-1:0] vld;
    logic [31:0]  data;
  } rsp_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] expGnt;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req;
  logic [N-1:0][31:0]     addr;
  logic [N-1:0]           gnt;
  logic [N-1:0]           stall;
  logic [N-1:0]           rvalid;
  logic [31:0]            rdata;
  logic                   memEn;
  logic [31:0]            memAddr;
  logic [31:0]            memRdata = '0;
  logic [N-1:0][WW-1:0]   waitCnt;

  int   total = 0;
  int   bad   = 0;
  int   mPtr;
  int   mWait [N];
  int   peak  [N];
  rsp_t sbq [$];
  vec_t vecs [19];

  imem_rr_arbiter #(.nCPUs(N), .WAIT_W(WW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .stall    (stall),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .memEn    (memEn),
    .memAddr  (memAddr),
    .memRdata (memRdata),
    .waitCnt  (waitCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h30) return 32'h00100513;
    return {a[15:0], ~a[31:16]};
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (memEn) memRdata <= memFn(memAddr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mPtr = 0;
    for (int i = 0; i < N; i++) mWait[i] = 0;
    sbq.delete();
  endtask

  // Called at the falling edge: compare all outputs against the model,
  // then advance the model to the state after the next rising edge.
  task automatic evalCycle();
    logic [N-1:0] eg;
    logic [31:0]  ea;
    rsp_t         e;
    eg = '0;
    ea = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mPtr + k) % N;
      if (req[i] && eg == '0) begin
        eg[i] = 1'b1;
        ea    = addr[i];
      end
    end
    chk("gnt", 32'(gnt), 32'(eg));
    chk("stall", 32'(stall), 32'(req & ~eg));
    chk("memEn", 32'(memEn), 32'(|req));
    chk("memAddr", memAddr, ea);
    if (sbq.size() > 0) e = sbq.pop_front();
    else begin
      e.vld  = '0;
      e.data = '0;
    end
    chk("rvalid", 32'(rvalid), 32'(e.vld));
    if (e.vld != '0) chk("rdata", rdata, e.data);
    for (int i = 0; i < N; i++) begin
      chk("waitCnt", 32'(waitCnt[i]), 32'(mWait[i]));
      if (int'(waitCnt[i]) > peak[i]) peak[i] = int'(waitCnt[i]);
    end
    if (!rst) begin
      resetModel();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || eg[i]) mWait[i] = 0;
        else if (mWait[i] < (1 << WW) - 1) mWait[i] = mWait[i] + 1;
      end
      for (int i = 0; i < N; i++) begin
        if (eg[i]) mPtr = (i + 1) % N;
      end
      e.vld  = eg;
      e.data = memFn(ea);
      sbq.push_back(e);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r);
    req = r;
    @(negedge clk);
    evalCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // contention: 9 cycles of all requesting
    for (int k = 0; k < 9; k++) begin
      vecs[k].req = 3'b111;
      case (k % 3)
        0:       vecs[k].expGnt = 3'b001;
        1:       vecs[k].expGnt = 3'b010;
        default: vecs[k].expGnt = 3'b100;
      endcase
    end
    // single requester, then idle, then pointer-held proof, then wrap/skip
    vecs[9]  = '{3'b010, 3'b010};
    vecs[10] = '{3'b010, 3'b010};
    vecs[11] = '{3'b010, 3'b010};
    vecs[12] = '{3'b000, 3'b000};
    vecs[13] = '{3'b111, 3'b100};
    vecs[14] = '{3'b001, 3'b001};
    vecs[15] = '{3'b101, 3'b100};
    vecs[16] = '{3'b101, 3'b001};
    vecs[17] = '{3'b101, 3'b100};
    vecs[18] = '{3'b000, 3'b000};

    for (int i = 0; i < N; i++) begin
      peak[i] = 0;
      addr[i] = 32'h100 * (i + 1);
    end
    addr[1] = 32'h30;
    resetModel();

    // Reset held with all CPUs requesting
    rst = 1'b0;
    req = 3'b111;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h1);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    cyc(3'b111);
    cyc(3'b111);
    rst = 1'b1;

    // Table-driven section
    for (int k = 0; k < 19; k++) begin
      req = vecs[k].req;
      @(negedge clk);
      chk("tbl_gnt", 32'(gnt), 32'(vecs[k].expGnt));
      if (k == 9) for (int i = 0; i < N; i++) peak[i] = 0;
      evalCycle();
      if (k == 8) begin
        for (int i = 0; i < N; i++) chk("waitPeak", 32'(peak[i]), 32'd2);
      end
      if (k == 10) chk("single_rdata", rdata, 32'h00100513);
      if (k == 13) chk("idle_rvalid", 32'(rvalid), 32'h0);
      @(posedge clk);
      #1;
    end

    // Random requests with addresses changing every cycle
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) addr[i] = $urandom;
      cyc(N'($urandom_range(0, 7)));
    end

    // Mid-operation reset between a grant and its edge
    cyc(3'b001);
    cyc(3'b111);
    req = 3'b111;
    @(negedge clk);
    evalCycle();
    #1;
    rst = 1'b0;
    resetModel();
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    cyc(3'b111);
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    chk("postrst_gnt", 32'(gnt), 32'h1);
    evalCycle();
    @(posedge clk);
    #1;
    cyc(3'b110);
    cyc(3'b000);
    cyc(3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
